// File: rtl/tt_scan_ctrl.sv
// Scan-chain master: serially loads a CHAIN_LEN-bit word MSB first and captures the old contents.
// Optional TT_SCAN_CTRL_LOOPBACK_CHECK_EN adds o_mismatch (capture vs previously loaded word).
module tt_scan_ctrl #(
   parameter int CHAIN_LEN = 4,
   parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_start,
   input  logic [CHAIN_LEN-1:0] i_wdata,
   output logic                 o_busy,
   output logic                 o_done,
   output logic [CHAIN_LEN-1:0] o_rdata,
   output logic                 o_scan_en,
   output logic                 o_scan_in,
`ifdef TT_SCAN_CTRL_LOOPBACK_CHECK_EN
   output logic                 o_mismatch,
`endif
   input  logic                 i_scan_out
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [CHAIN_LEN-1:0] shift_q, shift_d, cap_q, cap_d, rdata_q, rdata_d;
   logic                 en_q, en_d, sin_q, sin_d, done_q, done_d, busy_q, busy_d;
   logic [CHAIN_LEN-1:0] shift_rot, cap_shift;
   logic                 cnt_last;

   // Rotating rather than shifting leaves the loaded word intact after CHAIN_LEN steps.
   assign shift_rot = (shift_q << 1) | (shift_q >> (CHAIN_LEN - 1));
   assign cap_shift = (cap_q << 1) | CHAIN_LEN'(i_scan_out);
   assign cnt_last  = (cnt_q == CNT_W'(CHAIN_LEN - 1));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (i_start) state_d = SHIFT;
         SHIFT:   if (cnt_last) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

`ifdef TT_SCAN_CTRL_LOOPBACK_CHECK_EN
   logic [CHAIN_LEN-1:0] prev_q, prev_d;
   logic                 mis_q, mis_d;
`endif

   // Next values of every registered output; nothing reaches a port combinationally.
   always_comb begin
      en_d    = 1'b0;
      sin_d   = 1'b0;
      done_d  = 1'b0;
      busy_d  = 1'b0;
      shift_d = shift_q;
      cap_d   = cap_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
`ifdef TT_SCAN_CTRL_LOOPBACK_CHECK_EN
      prev_d  = prev_q;
      mis_d   = mis_q;
`endif
      case (state_q)
         IDLE: if (i_start) begin
            shift_d = i_wdata;
            en_d    = 1'b1;
            sin_d   = i_wdata[CHAIN_LEN-1];
            busy_d  = 1'b1;
            cnt_d   = '0;
         end
         SHIFT: begin
            busy_d  = 1'b1;
            shift_d = shift_rot;
            cap_d   = cap_shift;
            if (cnt_last) begin
               done_d  = 1'b1;
               rdata_d = cap_shift;
               cnt_d   = '0;
`ifdef TT_SCAN_CTRL_LOOPBACK_CHECK_EN
               mis_d   = (cap_shift != prev_q);
               prev_d  = shift_rot;
`endif
            end else begin
               en_d  = 1'b1;
               sin_d = shift_rot[CHAIN_LEN-1];
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         en_q    <= 1'b0;
         sin_q   <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         shift_q <= '0;
         cap_q   <= '0;
         cnt_q   <= '0;
         rdata_q <= '0;
`ifdef TT_SCAN_CTRL_LOOPBACK_CHECK_EN
         prev_q  <= '0;
         mis_q   <= 1'b0;
`endif
      end else begin
         en_q    <= en_d;
         sin_q   <= sin_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         shift_q <= shift_d;
         cap_q   <= cap_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
`ifdef TT_SCAN_CTRL_LOOPBACK_CHECK_EN
         prev_q  <= prev_d;
         mis_q   <= mis_d;
`endif
      end
   end

   assign o_scan_en = en_q;
   assign o_scan_in = sin_q;
   assign o_done    = done_q;
   assign o_busy    = busy_q;
   assign o_rdata   = rdata_q;
`ifdef TT_SCAN_CTRL_LOOPBACK_CHECK_EN
   assign o_mismatch = mis_q;
`endif

endmodule

// File: tb/tb_tt_scan_ctrl.sv
// Bench for tt_scan_ctrl against a 4-flop rising-edge chain model.
module tb_tt_scan_ctrl;
   localparam int N = 4;

   logic         i_clk = 1'b0;
   logic         i_rst, i_start, i_scan_out;
   logic [N-1:0] i_wdata;
   logic         o_busy, o_done, o_scan_en, o_scan_in;
   logic [N-1:0] o_rdata;
`ifdef TT_SCAN_CTRL_LOOPBACK_CHECK_EN
   logic         o_mismatch;
`endif

   int n_chk = 0;
   int n_err = 0;

   tt_scan_ctrl #(.CHAIN_LEN(N)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_wdata(i_wdata),
      .o_busy(o_busy), .o_done(o_done), .o_rdata(o_rdata),
      .o_scan_en(o_scan_en), .o_scan_in(o_scan_in),
`ifdef TT_SCAN_CTRL_LOOPBACK_CHECK_EN
      .o_mismatch(o_mismatch),
`endif
      .i_scan_out(i_scan_out)
   );

   always #5 i_clk = ~i_clk;

   // External chain: flop 0 nearest scan_in, scan_out from flop N-1.
   logic [N-1:0] chain;
   logic         ld = 1'b0;
   logic [N-1:0] ld_val = '0;
   always @(posedge i_clk) begin
      if (ld)             chain <= ld_val;
      else if (o_scan_en) chain <= {chain[N-2:0], o_scan_in};
   end
   assign i_scan_out = chain[N-1];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   task automatic preload(input logic [N-1:0] v);
      @(negedge i_clk);
      ld = 1'b1; ld_val = v;
      @(posedge i_clk); #1;
      ld = 1'b0;
   endtask

   // One full pass; exp_rd is what the chain held before the pass.
   task automatic run_pass(input logic [N-1:0] w, input logic [N-1:0] exp_rd, input string tag);
      logic [N-1:0] ser;
      int en_cnt;
      ser = '0; en_cnt = 0;
      @(negedge i_clk);
      i_start = 1'b1; i_wdata = w;
      @(posedge i_clk); #1;
      i_start = 1'b0; i_wdata = N'($urandom);
      for (int c = 1; c <= N; c++) begin
         @(negedge i_clk);
         if (o_scan_en) en_cnt++;
         ser[N-c] = o_scan_in;
         if (c == 2) i_start = 1'b1;   // must be ignored while busy
         if (c == 3) i_start = 1'b0;
         chk({tag, " busy_shift"}, o_busy, 1);
         chk({tag, " done_shift"}, o_done, 0);
      end
      chk({tag, " scan_en_cycles"}, en_cnt, N);
      chk({tag, " scan_in_serial"}, ser, w);
      @(negedge i_clk);
      chk({tag, " done_pulse"}, {o_done, o_busy, o_scan_en}, 3'b110);
      chk({tag, " rdata"}, o_rdata, exp_rd);
      @(negedge i_clk);
      chk({tag, " after_done"}, {o_done, o_busy, o_scan_en}, 3'b000);
      chk({tag, " chain_loaded"}, chain, w);
      chk({tag, " rdata_hold"}, o_rdata, exp_rd);
   endtask

   typedef struct {
      logic [N-1:0] pre;
      logic [N-1:0] wdata;
      logic [N-1:0] exp_rdata;
   } vec_t;

   vec_t         vecs[5];
   logic [N-1:0] prev;
   logic [20:0]  mask;
   int           en_cnt;
   logic         saw_done;

   initial begin
      vecs[0] = '{4'b0110, 4'b1001, 4'b0110};
      vecs[1] = '{4'b0000, 4'b1111, 4'b0000};
      vecs[2] = '{4'b1111, 4'b0000, 4'b1111};
      vecs[3] = '{4'b1010, 4'b0101, 4'b1010};
      vecs[4] = '{4'b1000, 4'b0001, 4'b1000};

      i_rst = 1'b1; i_start = 1'b0; i_wdata = '0;
      #1;
      chk("reset_async_outputs", {o_scan_en, o_scan_in, o_busy, o_done}, 4'b0000);
      repeat (2) @(negedge i_clk);
      i_rst = 1'b0;
      repeat (10) @(negedge i_clk);
      chk("idle_outputs", {o_scan_en, o_scan_in, o_busy, o_done}, 4'b0000);
      chk("idle_rdata", o_rdata, 0);

      foreach (vecs[i]) begin
         preload(vecs[i].pre);
         run_pass(vecs[i].wdata, vecs[i].exp_rdata, $sformatf("vec%0d", i));
      end

      // Write then clear: second pass reads back the first word, chain ends zero.
      run_pass(4'b0110, 4'b0001, "gen_w1");
      run_pass(4'b0000, 4'b0110, "gen_w2");

      // Held start: passes at edges 0,6,12,18; done in cycles 5,11,17.
      mask = '0; en_cnt = 0;
      @(negedge i_clk);
      i_start = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge i_clk);
         if (o_done) mask[k] = 1'b1;
         if (o_scan_en) en_cnt++;
         i_wdata = N'($urandom);
      end
      i_start = 1'b0;
      chk("held_start_done_cycles", mask, 21'((1 << 5) | (1 << 11) | (1 << 17)));
      chk("held_start_en_cycles", en_cnt, 14);
      repeat (6) @(negedge i_clk);
      chk("held_start_drained", {o_busy, o_scan_en}, 2'b00);

      // Reset in cycle 2 of SHIFT.
      preload(4'b0011);
      @(negedge i_clk);
      i_start = 1'b1; i_wdata = 4'b1100;
      @(posedge i_clk); #1;
      i_start = 1'b0;
      @(negedge i_clk);
      chk("pre_reset_scan_en", o_scan_en, 1);
      @(negedge i_clk);
      i_rst = 1'b1;
      #1;
      chk("midshift_reset_outputs", {o_scan_en, o_scan_in, o_busy, o_done}, 4'b0000);
      @(negedge i_clk);
      i_rst = 1'b0;
      saw_done = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge i_clk);
         if (o_done || o_busy) saw_done = 1'b1;
      end
      chk("midshift_no_done", saw_done, 0);
      preload(4'b0101);
      run_pass(4'b1111, 4'b0101, "post_reset");

      // Random passes: the chain always holds the last written word.
      prev = N'($urandom);
      preload(prev);
      for (int r = 0; r < 25; r++) begin
         logic [N-1:0] w;
         w = N'($urandom);
         run_pass(w, prev, $sformatf("rnd%0d", r));
         prev = w;
      end

`ifdef TT_SCAN_CTRL_LOOPBACK_CHECK_EN
      run_pass(4'b1010, prev, "lb_w1");
      run_pass(4'b0000, 4'b1010, "lb_w2");
      chk("loopback_match", o_mismatch, 0);
      preload(chain ^ 4'b0100);
      run_pass(4'b0000, 4'b0100, "lb_w3");
      chk("loopback_mismatch", o_mismatch, 1);
`endif

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/tt_scan_ctrl.md
Name: tt_scan_ctrl

Overview:
- Scan-chain master for the clock-generator scan chains: drives scan_en and scan_in, and reads back scan_out.
- Shifts a CHAIN_LEN-bit word into an external chain while capturing the word shifted out, in one serial pass.
- Sits between the debug/config register interface and blocks such as the divide-by-3 clock generator, which is a 4-flop chain.

Parameters:
- CHAIN_LEN, 4, number of scan flops in the attached chain (>=1).
- CNT_W, $clog2(CHAIN_LEN+1), width of the shift counter.

Ports:
- i_clk  input  1  single block clock; all state on the rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_start  input  1  request one scan pass; sampled only in IDLE.
- i_wdata  input  CHAIN_LEN  word to load; after the pass, chain flop k (k=0 nearest scan_in) holds i_wdata[k].
- o_busy  output  1  high in SHIFT and DONE.
- o_done  output  1  one-cycle pulse when the pass completes.
- o_rdata  output  CHAIN_LEN  chain contents captured before the pass; rdata[k] = flop k pre-pass.
- o_scan_en  output  1  to chain i_scan_en.
- o_scan_in  output  1  to chain i_scan_in.
- i_scan_out  input  1  from chain o_scan_out.

Behaviour:
- Reset, asynchronous and immediate:
  - state=IDLE, counter=0.
  - o_scan_en=0, o_scan_in=0, o_done=0, o_busy=0, o_rdata=0.
  - shift and capture registers cleared.
- All outputs are registered; no combinational path from any input to any output.
- FSM IDLE -> SHIFT -> DONE -> IDLE.
- IDLE:
  - o_scan_en=0, o_scan_in=0.
  - Rising edge with i_start=1: latch i_wdata into the shift register, go to SHIFT, set o_scan_en=1, o_scan_in=i_wdata[CHAIN_LEN-1], counter=0.
- SHIFT:
  - Exactly CHAIN_LEN consecutive cycles with o_scan_en=1.
  - On each rising edge in SHIFT: sample i_scan_out, then left-shift the shift register so o_scan_in presents the next lower bit (MSB first), and increment the counter.
  - Sample j (j=0..CHAIN_LEN-1) goes to capture bit CHAIN_LEN-1-j.
  - On the edge where counter reaches CHAIN_LEN-1: go to DONE, o_scan_en=0, o_scan_in=0.
- DONE:
  - One cycle: o_done=1, o_rdata=capture register. o_rdata holds until the next DONE or reset.
  - Next edge returns to IDLE.
- Latency: i_start sampled at edge 0; o_scan_en high during cycles 1..CHAIN_LEN; o_done high in cycle CHAIN_LEN+1. A new start is accepted at the earliest at edge CHAIN_LEN+2.
- i_start while busy: ignored, not queued. i_wdata is don't-care outside the accepting edge.
- Chain compatibility:
  - o_scan_en is driven from a rising-edge flop and is high for exactly CHAIN_LEN rising and CHAIN_LEN falling edges.
  - A mixed-edge chain (rising-edge segment followed by falling-edge segment) therefore shifts exactly CHAIN_LEN positions per pass.
- Reset mid-SHIFT:
  - o_scan_en drops asynchronously; the partial pass is discarded and o_done does not pulse.
  - Chain contents are then undefined; the chain's own reset governs them.
- CHAIN_LEN=1: SHIFT lasts one cycle; counter wrap is handled without overflow.

Optional Feature:
- Macro TT_SCAN_CTRL_LOOPBACK_CHECK_EN.
- Defined:
  - Adds port o_mismatch (output, 1) and a CHAIN_LEN-bit register of the previously loaded word, reset to 0.
  - In DONE, o_mismatch is registered as (capture != previous word) and held until the next DONE; then previous word := current word.
  - The first pass after reset compares against 0.
  - Reset value of o_mismatch is 0.
- Undefined: no o_mismatch port, no extra register; behaviour otherwise identical.

Test Plan:
- Reset, then idle 10 cycles with i_start=0 -> o_scan_en, o_scan_in, o_busy, o_done all 0; o_rdata=0.
- CHAIN_LEN=4 against a 4-flop rising-edge model preloaded with 4'b0110; start with i_wdata=4'b1001 -> o_scan_en high exactly cycles 1-4; serial o_scan_in 1,0,0,1; model=4'b1001; o_done pulses cycle 5; o_rdata=4'b0110.
- Attached to the divide-by-3 generator chain (flops pos0,pos1,neg0,neg1); write 4'b0110, then write 4'b0000 -> second pass o_rdata=4'b0110; the chain holds 0s.
- i_start held high continuously for 20 cycles -> passes start at edges 0, 6, 12, 18; i_start during busy is ignored; o_done at cycles 5, 11, 17.
- Assert i_rst in cycle 2 of SHIFT -> o_scan_en=0 the same cycle, no o_done; after release, a fresh start with 4'b1111 completes normally.
- With TT_SCAN_CTRL_LOOPBACK_CHECK_EN:
  - Write 4'b1010, then write 4'b0000 -> o_mismatch=0 after the second pass.
  - Flip the model's flop 2 between the passes -> o_mismatch=1.
